// File: rtl/acondicionador_botones.sv
// -----------------------------------------------------------------------------
// acondicionador_botones
//
// Front-end conditioner for the four active-low clock pushbuttons. Each raw pad
// goes through a 2-FF synchronizer, a debounce counter and a stable register,
// and produces a clean active-low level plus a one-cycle active-high press
// pulse. All outputs are registered.
//
// Optional feature macro: AUTOREPEAT_EN
//   Defined   -> incrementar/decrementar get an IDLE/HOLD/REPEAT machine that
//                keeps pulsing while the button stays held.
//   Undefined -> every channel pulses exactly once per debounced press.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles the synchronized input must differ before flipping
//   HOLD_CYCLES      cycles after the press pulse before the first repeat
//   REPEAT_CYCLES    spacing between repeat pulses
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   *_in                             raw asynchronous pads, active-low
//   incrementar..establecer          debounced levels, active-low
//   pulso_*                          press pulses, active-high, 1 cycle
// -----------------------------------------------------------------------------
module acondicionador_botones #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int HOLD_CYCLES     = 8,
   parameter int REPEAT_CYCLES   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic incrementar_in,
   input  logic decrementar_in,
   input  logic cambiar_in,
   input  logic establecer_in,
   output logic incrementar,
   output logic decrementar,
   output logic cambiar,
   output logic establecer,
   output logic pulso_incrementar,
   output logic pulso_decrementar,
   output logic pulso_cambiar,
   output logic pulso_establecer
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Elaboration-time sanity checks on the timing parameters.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
   end

`ifdef AUTOREPEAT_EN
   localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;
`endif

   // Channel order: 0 incrementar, 1 decrementar, 2 cambiar, 3 establecer.
   logic [3:0] raw;
   logic [3:0] level;
   logic [3:0] pulse;

   assign raw = {establecer_in, cambiar_in, decrementar_in, incrementar_in};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic          sync1_reg, sync2_reg, stable_reg, pulse_reg;
         logic          stable_next;
         logic [CW-1:0] cnt_reg, cnt_next;
         logic          flip;
         logic          press_evt;
         logic          release_evt;
         logic          rep_evt;

         // Any cycle where sync2 matches stable clears the count, so a bounce
         // back restarts the qualification window from scratch.
         always_comb begin
            cnt_next    = '0;
            stable_next = stable_reg;
            flip        = 1'b0;
            if (sync2_reg != stable_reg) begin
               if (cnt_reg == CNT_LAST) begin
                  flip        = 1'b1;
                  stable_next = sync2_reg;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         // stable currently 1 and flipping means a press; currently 0 means release.
         assign press_evt   = flip & stable_reg;
         assign release_evt = flip & ~stable_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg  <= 1'b1;
               sync2_reg  <= 1'b1;
               stable_reg <= 1'b1;
               cnt_reg    <= '0;
               pulse_reg  <= 1'b0;
            end else begin
               sync1_reg  <= raw[gi];
               sync2_reg  <= sync1_reg;
               stable_reg <= stable_next;
               cnt_reg    <= cnt_next;
               pulse_reg  <= press_evt | rep_evt;
            end
         end

`ifdef AUTOREPEAT_EN
         if (gi < 2) begin : g_rep
            rep_state_t    state_reg, state_next;
            logic [RW-1:0] rcnt_reg, rcnt_next;
            logic          rep_c;

            always_ff @(posedge clk) begin
               if (reset) begin
                  state_reg <= IDLE;
                  rcnt_reg  <= '0;
               end else begin
                  state_reg <= state_next;
                  rcnt_reg  <= rcnt_next;
               end
            end

            // Release wins over everything, which also suppresses a repeat
            // pulse that would otherwise land in the release cycle.
            always_comb begin
               state_next = state_reg;
               rcnt_next  = rcnt_reg;
               rep_c      = 1'b0;
               if (release_evt) begin
                  state_next = IDLE;
                  rcnt_next  = '0;
               end else begin
                  case (state_reg)
                     IDLE: begin
                        if (press_evt) begin
                           state_next = HOLD;
                           rcnt_next  = '0;
                        end
                     end
                     HOLD: begin
                        if (rcnt_reg == HOLD_LAST) begin
                           rep_c      = 1'b1;
                           state_next = REPEAT;
                           rcnt_next  = '0;
                        end else begin
                           rcnt_next = rcnt_reg + RW'(1);
                        end
                     end
                     REPEAT: begin
                        if (rcnt_reg == REP_LAST) begin
                           rep_c     = 1'b1;
                           rcnt_next = '0;
                        end else begin
                           rcnt_next = rcnt_reg + RW'(1);
                        end
                     end
                     default: begin
                        state_next = IDLE;
                        rcnt_next  = '0;
                     end
                  endcase
               end
            end

            assign rep_evt = rep_c;
         end else begin : g_norep
            assign rep_evt = 1'b0;
         end
`else
         assign rep_evt = 1'b0;
`endif

         assign level[gi] = stable_reg;
         assign pulse[gi] = pulse_reg;
      end
   endgenerate

   assign incrementar       = level[0];
   assign decrementar       = level[1];
   assign cambiar           = level[2];
   assign establecer        = level[3];
   assign pulso_incrementar = pulse[0];
   assign pulso_decrementar = pulse[1];
   assign pulso_cambiar     = pulse[2];
   assign pulso_establecer  = pulse[3];

endmodule

// File: tb/tb_acondicionador_botones.sv
// -----------------------------------------------------------------------------
// Testbench for acondicionador_botones. Expected press/repeat pulses are pushed
// into a scoreboard when stimulus is applied; a monitor pops and compares them
// whenever the DUT pulses. Level outputs are checked inline by each scenario.
// -----------------------------------------------------------------------------
module tb_acondicionador_botones;

   localparam int D = 20;
   localparam int H = 8;
   localparam int R = 4;

   logic clk = 1'b0;
   logic reset;
   logic incrementar_in, decrementar_in, cambiar_in, establecer_in;
   logic incrementar, decrementar, cambiar, establecer;
   logic pulso_incrementar, pulso_decrementar, pulso_cambiar, pulso_establecer;

   acondicionador_botones #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .incrementar_in   (incrementar_in),
      .decrementar_in   (decrementar_in),
      .cambiar_in       (cambiar_in),
      .establecer_in    (establecer_in),
      .incrementar      (incrementar),
      .decrementar      (decrementar),
      .cambiar          (cambiar),
      .establecer       (establecer),
      .pulso_incrementar(pulso_incrementar),
      .pulso_decrementar(pulso_decrementar),
      .pulso_cambiar    (pulso_cambiar),
      .pulso_establecer (pulso_establecer)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far.
   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   logic [3:0] pulses, levels;
   assign pulses = {pulso_establecer, pulso_cambiar, pulso_decrementar, pulso_incrementar};
   assign levels = {establecer, cambiar, decrementar, incrementar};

   typedef struct {
      int ch;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic push_exp(input int ch, input int cyc);
      exp_t e;
      e.ch  = ch;
      e.cyc = cyc;
      exp_q.push_back(e);
   endtask

`ifdef AUTOREPEAT_EN
   // Repeat pulses after a press pulse at edge p, up to (not including) the
   // edge where the debounced release lands.
   task automatic push_repeats(input int ch, input int p, input int rel);
      int t;
      t = p + H;
      while (t < rel) begin
         push_exp(ch, t);
         t = t + R;
      end
   endtask
`endif

   // Scoreboard monitor: every observed pulse must match the earliest
   // outstanding expectation for that channel.
   always @(negedge clk) begin
      int idx;
      for (int c = 0; c < 4; c++) begin
         if (pulses[c] === 1'b1) begin
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
               if (idx < 0 && exp_q[k].ch == c) idx = k;
            end
            checks++;
            if (idx < 0) begin
               errors++;
               $display("FAIL unexpected_pulse ch%0d at edge %0d: got pulse, expected none", c, edges);
            end else begin
               if (exp_q[idx].cyc != edges) begin
                  errors++;
                  $display("FAIL pulse_edge ch%0d: got edge %0d expected edge %0d", c, edges, exp_q[idx].cyc);
               end else begin
                  $display("pulse ch%0d at edge %0d ok", c, edges);
               end
               exp_q.delete(idx);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      incrementar_in = 1'b1;
      decrementar_in = 1'b1;
      cambiar_in     = 1'b1;
      establecer_in  = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (levels !== 4'hF) begin
         errors++;
         $display("FAIL reset_levels: got %b expected 1111", levels);
      end
      checks++;
      if (pulses !== 4'h0) begin
         errors++;
         $display("FAIL reset_pulses: got %b expected 0000", pulses);
      end
      reset = 1'b0;
      repeat (50) begin
         @(negedge clk);
         checks++;
         if (levels !== 4'hF || pulses !== 4'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got levels %b pulses %b expected 1111 0000", levels, pulses);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_clean_press();
      int t0, t1;
      logic exp_l;
      t0 = edges;
      cambiar_in = 1'b0;
      push_exp(2, t0 + D + 2);
      repeat (40) begin
         @(negedge clk);
         exp_l = (edges >= t0 + D + 2) ? 1'b0 : 1'b1;
         checks++;
         if (cambiar !== exp_l) begin
            errors++;
            $display("FAIL press_level at edge %0d: got %b expected %b", edges, cambiar, exp_l);
         end
      end
      t1 = edges;
      cambiar_in = 1'b1;
      repeat (40) begin
         @(negedge clk);
         exp_l = (edges >= t1 + D + 2) ? 1'b1 : 1'b0;
         checks++;
         if (cambiar !== exp_l) begin
            errors++;
            $display("FAIL release_level at edge %0d: got %b expected %b", edges, cambiar, exp_l);
         end
      end
      $display("test_clean_press done");
   endtask

   task automatic test_bounce();
      int t0;
      for (int n = 0; n < 4; n++) begin
         establecer_in = 1'b0;
         repeat (5) begin
            @(negedge clk);
            checks++;
            if (establecer !== 1'b1) begin
               errors++;
               $display("FAIL bounce_level at edge %0d: got %b expected 1", edges, establecer);
            end
         end
         establecer_in = 1'b1;
         repeat (3) begin
            @(negedge clk);
            checks++;
            if (establecer !== 1'b1) begin
               errors++;
               $display("FAIL bounce_level at edge %0d: got %b expected 1", edges, establecer);
            end
         end
      end
      repeat (10) @(negedge clk);
      t0 = edges;
      establecer_in = 1'b0;
      push_exp(3, t0 + D + 2);
      repeat (25) @(negedge clk);
      checks++;
      if (establecer !== 1'b0) begin
         errors++;
         $display("FAIL clean_after_bounce: got %b expected 0", establecer);
      end
      establecer_in = 1'b1;
      repeat (30) @(negedge clk);
      $display("test_bounce done");
   endtask

`ifdef AUTOREPEAT_EN
   task automatic test_autorepeat();
      int t0, t1;
      t0 = edges;
      incrementar_in = 1'b0;
      push_exp(0, t0 + D + 2);
      t1 = t0 + 60;
      push_repeats(0, t0 + D + 2, t1 + D + 2);
      repeat (60) @(negedge clk);
      checks++;
      if (incrementar !== 1'b0) begin
         errors++;
         $display("FAIL held_level: got %b expected 0", incrementar);
      end
      incrementar_in = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (incrementar !== 1'b1) begin
         errors++;
         $display("FAIL released_level: got %b expected 1", incrementar);
      end
      $display("test_autorepeat done");
   endtask
`else
   task automatic test_no_repeat();
      int t0;
      t0 = edges;
      decrementar_in = 1'b0;
      push_exp(1, t0 + D + 2);
      repeat (100) @(negedge clk);
      checks++;
      if (decrementar !== 1'b0) begin
         errors++;
         $display("FAIL long_hold_level: got %b expected 0", decrementar);
      end
      decrementar_in = 1'b1;
      repeat (30) @(negedge clk);
      $display("test_no_repeat done");
   endtask
`endif

   task automatic test_simultaneous();
      int t0;
      logic [3:0] exp_l;
      t0 = edges;
      incrementar_in = 1'b0;
      decrementar_in = 1'b0;
      cambiar_in     = 1'b0;
      establecer_in  = 1'b0;
      for (int c = 0; c < 4; c++) push_exp(c, t0 + D + 2);
`ifdef AUTOREPEAT_EN
      push_repeats(0, t0 + D + 2, t0 + 30 + D + 2);
      push_repeats(1, t0 + D + 2, t0 + 30 + D + 2);
`endif
      repeat (30) begin
         @(negedge clk);
         exp_l = (edges >= t0 + D + 2) ? 4'h0 : 4'hF;
         checks++;
         if (levels !== exp_l) begin
            errors++;
            $display("FAIL simultaneous_levels at edge %0d: got %b expected %b", edges, levels, exp_l);
         end
      end
      incrementar_in = 1'b1;
      decrementar_in = 1'b1;
      cambiar_in     = 1'b1;
      establecer_in  = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (levels !== 4'hF) begin
         errors++;
         $display("FAIL simultaneous_release: got %b expected 1111", levels);
      end
      $display("test_simultaneous done");
   endtask

   task automatic test_reset_mid();
      int tr;
      logic exp_l;
      cambiar_in = 1'b0;
      repeat (15) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (cambiar !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_level: got %b expected 1", cambiar);
      end
      reset = 1'b0;
      tr = edges;
      push_exp(2, tr + D + 2);
      repeat (30) begin
         @(negedge clk);
         exp_l = (edges >= tr + D + 2) ? 1'b0 : 1'b1;
         checks++;
         if (cambiar !== exp_l) begin
            errors++;
            $display("FAIL post_reset_level at edge %0d: got %b expected %b", edges, cambiar, exp_l);
         end
      end
      cambiar_in = 1'b1;
      repeat (30) @(negedge clk);
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
`ifdef AUTOREPEAT_EN
      test_autorepeat();
`else
      test_no_repeat();
`endif
      test_simultaneous();
      test_reset_mid();
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         foreach (exp_q[k])
            $display("FAIL missing_pulse ch%0d: got none expected pulse at edge %0d", exp_q[k].ch, exp_q[k].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acondicionador_botones.md
# acondicionador_botones

Front-end conditioner for the four active-low pushbuttons (incrementar, decrementar, cambiar, establecer) of the digital clock. It sits directly upstream of the mode-control block. Each raw pad input is synchronized, debounced and converted into a clean active-low level plus a one-cycle active-high press pulse. Optional auto-repeat on incrementar/decrementar lets a held button step the time being set.

## Interface
- DEBOUNCE_CYCLES, 20: consecutive cycles a synchronized input must differ from the stable value before the stable value flips (≥2).
- HOLD_CYCLES, 8: cycles a button must stay stably pressed after its press pulse before the first auto-repeat pulse (≥1).
- REPEAT_CYCLES, 4: spacing in cycles between auto-repeat pulses (≥1).
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- incrementar_in, decrementar_in, cambiar_in, establecer_in  in  1 each  raw asynchronous button pads, active-low (0 = pressed).
- incrementar, decrementar, cambiar, establecer  out  1 each  debounced stable levels, active-low; feed the mode-control block directly.
- pulso_incrementar, pulso_decrementar, pulso_cambiar, pulso_establecer  out  1 each  press pulse, active-high, exactly one cycle wide.

## Operation
- Four identical independent channels; no priority, no interaction. Any subset may pulse in the same cycle.
- Per channel: 2-FF synchronizer (sync1 → sync2), debounce counter, stable register, pulse register.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).
  - sync2 == stable: counter cleared to 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
- Any bounce back to the stable value before the count completes clears the counter. Glitches shorter than DEBOUNCE_CYCLES cycles never reach the outputs.
- Press pulse: asserted in the cycle in which stable goes 1→0. A release (0→1) produces no pulse.
- Auto-repeat state machine (incrementar/decrementar only, when compiled in). States: IDLE, HOLD, REPEAT.
  - IDLE → HOLD on the press pulse; repeat counter loaded to 0.
  - HOLD: counter increments each cycle. At HOLD_CYCLES, emit a pulse and go to REPEAT with the counter at 0.
  - REPEAT: emit a pulse every REPEAT_CYCLES cycles.
  - Stable release in any state → IDLE immediately. No pulse is emitted in the release cycle.
- cambiar/establecer never repeat: one pulse per debounced press.
- Reset values:
  - sync1, sync2, stable: 1 (released).
  - All counters: 0.
  - State: IDLE.
  - All pulse outputs: 0.
  - All level outputs: 1.
- Reset mid-debounce or mid-repeat discards all progress, with no pulse in the reset cycle. A button still held after reset release is treated as a new press and pulses after normal latency.

## Timing
- Press latency: raw falls before edge 0; sync1 low after edge 0; sync2 low after edge 1. Stable level goes low and the pulse goes high after edge 1+DEBOUNCE_CYCLES. The pulse is low again after edge 2+DEBOUNCE_CYCLES.
- Release latency: identical, 1+DEBOUNCE_CYCLES edges; no pulse.
- First auto-repeat pulse: HOLD_CYCLES cycles after the press pulse. Subsequent pulses: every REPEAT_CYCLES cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- AUTOREPEAT_EN defined: HOLD/REPEAT machine compiled into the incrementar and decrementar channels, as described above.
- AUTOREPEAT_EN undefined: the repeat logic is absent. Every channel emits exactly one pulse per debounced press, and HOLD_CYCLES/REPEAT_CYCLES are unused.

## Test plan
- **Reset defaults:** reset=1 for 3 cycles with all inputs 1 → all levels 1, all pulses 0. Release reset → outputs unchanged for 50 cycles.
- **Clean press:** DEBOUNCE_CYCLES=20, cambiar_in 1→0 held 40 cycles → cambiar low and pulso_cambiar high exactly at edge 21, pulse width 1 cycle. Release → cambiar high 21 edges later, no pulse.
- **Bounce rejection:** establecer_in toggles low for 5 cycles, high for 3, repeated 4 times, then stays high → no pulse, establecer stays 1. Then a clean low for 25 cycles → exactly one pulse.
- **Auto-repeat (AUTOREPEAT_EN, HOLD_CYCLES=8, REPEAT_CYCLES=4):** incrementar_in held low 60 cycles → pulses at edges 21, 29, 33, 37, … until release. No pulse after stable release.
- **Simultaneous and no macro:** all four inputs fall in the same cycle → all four pulses high in the same cycle (edge 21). Without AUTOREPEAT_EN, decrementar held 100 cycles → exactly one pulse.
- **Reset mid-operation:** assert reset at cycle 15 of a held press, release at cycle 17 with the button still held → no pulse before reset release; one pulse at 21 edges after reset release.
